// File: rtl/sirv_qspi_arbiter_n_if.sv
// Bundle of all inner/outer link, select and owner signals around the QSPI arbiter.
// slave: arbiter side; master: surrounding front-ends, link engine and software control.
interface sirv_qspi_arbiter_n_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned SELW = 2,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8
);
  logic [N_CH-1:0]    io_inner_tx_ready;
  logic [N_CH-1:0]    io_inner_tx_valid;
  logic [N_CH*DW-1:0] io_inner_tx_bits;
  logic [N_CH-1:0]    io_inner_rx_valid;
  logic [DW-1:0]      io_inner_rx_bits;
  logic [N_CH*CW-1:0] io_inner_cnt;
  logic [N_CH*2-1:0]  io_inner_fmt_proto;
  logic [N_CH-1:0]    io_inner_fmt_endian;
  logic [N_CH-1:0]    io_inner_fmt_iodir;
  logic [N_CH-1:0]    io_inner_cs_set;
  logic [N_CH-1:0]    io_inner_cs_clear;
  logic [N_CH-1:0]    io_inner_cs_hold;
  logic [N_CH-1:0]    io_inner_active;
  logic [N_CH-1:0]    io_inner_lock;
  logic               io_outer_tx_ready;
  logic               io_outer_tx_valid;
  logic [DW-1:0]      io_outer_tx_bits;
  logic               io_outer_rx_valid;
  logic [DW-1:0]      io_outer_rx_bits;
  logic [CW-1:0]      io_outer_cnt;
  logic [1:0]         io_outer_fmt_proto;
  logic               io_outer_fmt_endian;
  logic               io_outer_fmt_iodir;
  logic               io_outer_cs_set;
  logic               io_outer_cs_clear;
  logic               io_outer_cs_hold;
  logic               io_outer_active;
  logic [SELW-1:0]    io_sel;
  logic               io_rr_en;
  logic [SELW-1:0]    io_owner;

  modport slave (
    output io_inner_tx_ready, io_inner_rx_valid, io_inner_rx_bits, io_inner_active,
    output io_outer_tx_valid, io_outer_tx_bits, io_outer_cnt, io_outer_fmt_proto,
    output io_outer_fmt_endian, io_outer_fmt_iodir, io_outer_cs_set, io_outer_cs_clear,
    output io_outer_cs_hold, io_owner,
    input  io_inner_tx_valid, io_inner_tx_bits, io_inner_cnt, io_inner_fmt_proto,
    input  io_inner_fmt_endian, io_inner_fmt_iodir, io_inner_cs_set, io_inner_cs_clear,
    input  io_inner_cs_hold, io_inner_lock, io_outer_tx_ready, io_outer_rx_valid,
    input  io_outer_rx_bits, io_outer_active, io_sel, io_rr_en
  );

  modport master (
    input  io_inner_tx_ready, io_inner_rx_valid, io_inner_rx_bits, io_inner_active,
    input  io_outer_tx_valid, io_outer_tx_bits, io_outer_cnt, io_outer_fmt_proto,
    input  io_outer_fmt_endian, io_outer_fmt_iodir, io_outer_cs_set, io_outer_cs_clear,
    input  io_outer_cs_hold, io_owner,
    output io_inner_tx_valid, io_inner_tx_bits, io_inner_cnt, io_inner_fmt_proto,
    output io_inner_fmt_endian, io_inner_fmt_iodir, io_inner_cs_set, io_inner_cs_clear,
    output io_inner_cs_hold, io_inner_lock, io_outer_tx_ready, io_outer_rx_valid,
    output io_outer_rx_bits, io_outer_active, io_sel, io_rr_en
  );
endinterface

// File: rtl/sirv_qspi_arbiter_n.sv
// N-channel QSPI link arbiter: software-select or round-robin owner, with a drain/clear
// switch sequence so the outer link never sees a transfer straddle an owner change.
module sirv_qspi_arbiter_n #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned SELW = 2,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8
) (
  input logic                   clock,
  input logic                   reset,
  sirv_qspi_arbiter_n_if.slave  bus_io
);

  typedef enum logic [1:0] {StRun, StDrain, StClear} state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] owner_q, owner_d;
  logic [SELW-1:0] pend_q, pend_d;
  logic [SELW-1:0] target;
  logic [N_CH-1:0] own_oh;
  logic            own_valid, own_lock, found;

  always_comb begin
    own_oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      own_oh[i] = (owner_q == SELW'(i));
    end
  end

  assign own_valid = |(own_oh & bus_io.io_inner_tx_valid);
  assign own_lock  = |(own_oh & bus_io.io_inner_lock);

  // Round-robin scans outward from the owner by increasing distance, wrapping at N_CH.
  always_comb begin
    target = owner_q;
    found  = 1'b0;
    if (!bus_io.io_rr_en) begin
      if ({1'b0, bus_io.io_sel} < (SELW+1)'(N_CH)) begin
        target = bus_io.io_sel;
      end
    end else if (!own_valid) begin
      for (int k = 1; k < N_CH; k++) begin
        for (int j = 0; j < N_CH; j++) begin
          if (!found && own_oh[j] && bus_io.io_inner_tx_valid[(j + k) % N_CH]) begin
            target = SELW'((j + k) % N_CH);
            found  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    pend_d  = pend_q;
    unique case (state_q)
      StRun: begin
        if (target != owner_q && !own_lock) begin
          pend_d  = target;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!bus_io.io_outer_active) begin
          owner_d = pend_q;
          state_d = StClear;
        end
      end
      StClear: state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
      owner_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pend_q  <= pend_d;
    end
  end

  // Field mux follows the registered owner, so CLEAR already presents the new owner.
  always_comb begin
    bus_io.io_outer_tx_bits    = '0;
    bus_io.io_outer_cnt        = '0;
    bus_io.io_outer_fmt_proto  = '0;
    bus_io.io_outer_fmt_endian = 1'b0;
    bus_io.io_outer_fmt_iodir  = 1'b0;
    bus_io.io_outer_cs_set     = 1'b0;
    bus_io.io_outer_cs_hold    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (own_oh[i]) begin
        bus_io.io_outer_tx_bits    = bus_io.io_inner_tx_bits[i*DW +: DW];
        bus_io.io_outer_cnt        = bus_io.io_inner_cnt[i*CW +: CW];
        bus_io.io_outer_fmt_proto  = bus_io.io_inner_fmt_proto[i*2 +: 2];
        bus_io.io_outer_fmt_endian = bus_io.io_inner_fmt_endian[i];
        bus_io.io_outer_fmt_iodir  = bus_io.io_inner_fmt_iodir[i];
        bus_io.io_outer_cs_set     = bus_io.io_inner_cs_set[i];
        bus_io.io_outer_cs_hold    = bus_io.io_inner_cs_hold[i];
      end
    end
  end

  always_comb begin
    bus_io.io_inner_rx_bits  = bus_io.io_outer_rx_bits;
    bus_io.io_inner_rx_valid = own_oh & {N_CH{bus_io.io_outer_rx_valid}};
    bus_io.io_inner_active   = own_oh & {N_CH{bus_io.io_outer_active}};
    bus_io.io_inner_tx_ready = '0;
    bus_io.io_outer_tx_valid = 1'b0;
    bus_io.io_outer_cs_clear = 1'b0;
    unique case (state_q)
      StRun: begin
        bus_io.io_outer_tx_valid = own_valid;
        bus_io.io_inner_tx_ready = own_oh & {N_CH{bus_io.io_outer_tx_ready}};
        bus_io.io_outer_cs_clear = |(own_oh & bus_io.io_inner_cs_clear);
      end
      StClear: bus_io.io_outer_cs_clear = 1'b1;
      default: ;
    endcase
  end

  assign bus_io.io_owner = owner_q;

endmodule
